// File: rtl/adder_result_buffer_if.sv
// Handshake bundle between the 32-bit adder (producer), the result buffer and the writeback consumer.
interface adder_result_buffer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sum, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sum, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_ovf
    );
endinterface

// File: rtl/adder_result_buffer.sv
// Registered, two-entry skid-buffered output stage for the 32-bit adder with carry/overflow flags.
// Optional sum self-check is enabled by defining ADDER_RESULT_CHECK_EN.
module adder_result_buffer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_result_buffer_if.slave bus,
    output logic [CNT_W-1:0]     result_cnt,
    output logic                 chk_err
);

    function automatic logic calc_carry(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] sum);
        return sum < a;
    endfunction

    // Signed overflow: operands share a sign that the sum does not.
    function automatic logic calc_ovf(input logic signed [WIDTH-1:0] a,
                                      input logic signed [WIDTH-1:0] b,
                                      input logic signed [WIDTH-1:0] sum);
        return ((a < 0) == (b < 0)) && ((sum < 0) != (a < 0));
    endfunction

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_sum_q,   main_sum_d;
    logic             main_carry_q, main_carry_d;
    logic             main_ovf_q,   main_ovf_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_sum_q,   skid_sum_d;
    logic             skid_carry_q, skid_carry_d;
    logic             skid_ovf_q,   skid_ovf_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;

    logic accept;
    logic xfer;
    logic new_carry;
    logic new_ovf;

    assign bus.in_ready  = !skid_valid_q;
    assign bus.out_valid = main_valid_q;
    assign bus.out_sum   = main_sum_q;
    assign bus.out_carry = main_carry_q;
    assign bus.out_ovf   = main_ovf_q;
    assign result_cnt    = cnt_q;

    always_comb begin
        accept    = bus.in_valid && !skid_valid_q;
        xfer      = main_valid_q && bus.out_ready;
        new_carry = calc_carry(bus.in_a, bus.in_sum);
        new_ovf   = calc_ovf(bus.in_a, bus.in_b, bus.in_sum);

        main_valid_d = main_valid_q;
        main_sum_d   = main_sum_q;
        main_carry_d = main_carry_q;
        main_ovf_d   = main_ovf_q;
        skid_valid_d = skid_valid_q;
        skid_sum_d   = skid_sum_q;
        skid_carry_d = skid_carry_q;
        skid_ovf_d   = skid_ovf_q;
        cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, xfer};

        if (!main_valid_q || xfer) begin
            // A full skid always drains first; in_ready is low then, so no accept competes.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_sum_d   = skid_sum_q;
                main_carry_d = skid_carry_q;
                main_ovf_d   = skid_ovf_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_sum_d   = bus.in_sum;
                main_carry_d = new_carry;
                main_ovf_d   = new_ovf;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_sum_d   = bus.in_sum;
            skid_carry_d = new_carry;
            skid_ovf_d   = new_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_sum_q   <= '0;
            main_carry_q <= 1'b0;
            main_ovf_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_sum_q   <= '0;
            skid_carry_q <= 1'b0;
            skid_ovf_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_sum_q   <= main_sum_d;
            main_carry_q <= main_carry_d;
            main_ovf_q   <= main_ovf_d;
            skid_valid_q <= skid_valid_d;
            skid_sum_q   <= skid_sum_d;
            skid_carry_q <= skid_carry_d;
            skid_ovf_q   <= skid_ovf_d;
            cnt_q        <= cnt_d;
        end
    end

`ifdef ADDER_RESULT_CHECK_EN
    logic             chk_err_q, chk_err_d;
    logic [WIDTH-1:0] recomputed;

    // Sticky: any accepted sum that disagrees with a+b latches the error until reset.
    always_comb begin
        recomputed = bus.in_a + bus.in_b;
        chk_err_d  = chk_err_q || (accept && (recomputed != bus.in_sum));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
        end else begin
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_adder_result_buffer.sv
// Directed self-checking bench for adder_result_buffer.
module tb_adder_result_buffer;

    logic        clk;
    logic        rst_n;
    logic [15:0] result_cnt;
    logic        chk_err;
    int          n_chk;
    int          n_fail;
    logic        exp_chk;

    adder_result_buffer_if #(.WIDTH(32)) bus ();

    adder_result_buffer #(.WIDTH(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .result_cnt (result_cnt),
        .chk_err    (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sum   = s;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
`ifdef ADDER_RESULT_CHECK_EN
        exp_chk = 1'b1;
`else
        exp_chk = 1'b0;
`endif
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_sum", bus.out_sum, 0);
        check("rst_cnt", result_cnt, 0);
        check("rst_chk_err", chk_err, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // basic 5+4
        bus.out_ready = 1'b1;
        drive(1'b1, 32'd5, 32'd4, 32'd9);
        tick();
        check("basic_valid", bus.out_valid, 1);
        check("basic_sum", bus.out_sum, 9);
        check("basic_carry", bus.out_carry, 0);
        check("basic_ovf", bus.out_ovf, 0);
        check("basic_cnt0", result_cnt, 0);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        check("basic_cnt1", result_cnt, 1);
        check("basic_empty", bus.out_valid, 0);

        // carry and signed overflow boundaries, back to back
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        tick();
        check("carry_sum", bus.out_sum, 0);
        check("carry_carry", bus.out_carry, 1);
        check("carry_ovf", bus.out_ovf, 0);
        drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
        tick();
        check("ovf_sum", bus.out_sum, 32'h8000_0000);
        check("ovf_carry", bus.out_carry, 0);
        check("ovf_ovf", bus.out_ovf, 1);
        check("ovf_cnt", result_cnt, 2);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        check("ovf_cnt3", result_cnt, 3);

        // backpressure: fill main and skid, third offer must wait
        bus.out_ready = 1'b0;
        drive(1'b1, 32'd13, 32'd66, 32'd79);
        tick();
        check("bp_first_sum", bus.out_sum, 79);
        check("bp_ready_after1", bus.in_ready, 1);
        drive(1'b1, 32'd749, 32'd619, 32'd1368);
        tick();
        check("bp_full_ready", bus.in_ready, 0);
        check("bp_hold_sum", bus.out_sum, 79);
        drive(1'b1, 32'd786, 32'd4932, 32'd5718);
        tick();
        check("bp_still_full", bus.in_ready, 0);
        check("bp_stable_sum", bus.out_sum, 79);
        check("bp_stable_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        tick();
        check("bp_second_sum", bus.out_sum, 1368);
        check("bp_ready_again", bus.in_ready, 1);
        check("bp_cnt4", result_cnt, 4);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        check("bp_third_sum", bus.out_sum, 5718);
        check("bp_cnt5", result_cnt, 5);
        tick();
        check("bp_cnt6", result_cnt, 6);
        check("bp_drained", bus.out_valid, 0);

        // asynchronous reset with both entries held
        bus.out_ready = 1'b0;
        drive(1'b1, 32'd1, 32'd2, 32'd3);
        tick();
        drive(1'b1, 32'd3, 32'd4, 32'd7);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        check("ar_full", bus.in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", bus.out_valid, 0);
        check("ar_in_ready", bus.in_ready, 1);
        check("ar_cnt", result_cnt, 0);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 32'd65035, 32'd555489, 32'd620524);
        tick();
        check("ar_new_sum", bus.out_sum, 620524);
        check("ar_new_valid", bus.out_valid, 1);
        check("ar_skid_empty", bus.in_ready, 1);
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        bus.out_ready = 1'b1;
        tick();
        check("ar_alone_empty", bus.out_valid, 0);
        check("ar_alone_cnt", result_cnt, 1);

        // streaming at full rate
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(i * 10 + 1), 32'(i + 100), 32'(i * 11 + 101));
            tick();
            check($sformatf("st_valid%0d", i), bus.out_valid, 1);
            check($sformatf("st_sum%0d", i), bus.out_sum, 64'(i * 11 + 101));
            check($sformatf("st_ready%0d", i), bus.in_ready, 1);
            check($sformatf("st_cnt%0d", i), result_cnt, 64'(i + 1));
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        check("st_cnt_end", result_cnt, 6);
        check("st_empty", bus.out_valid, 0);

        // sum self-check: wrong sum, then a correct one
        drive(1'b1, 32'd13, 32'd66, 32'd80);
        tick();
        check("chk_bad_sum", bus.out_sum, 80);
        check("chk_set", chk_err, 64'(exp_chk));
        drive(1'b1, 32'd1, 32'd1, 32'd2);
        tick();
        check("chk_sticky", chk_err, 64'(exp_chk));
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        check("chk_sticky2", chk_err, 64'(exp_chk));
        rst_n = 1'b0;
        #1;
        check("chk_cleared", chk_err, 0);
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_result_buffer.md
Name: adder_result_buffer

Overview:
- Registered output stage directly downstream of the 32-bit combinational adder.
- Captures the adder operands and the adder's sum with a valid/ready handshake and derives carry and signed-overflow flags.
- Holds up to two results in a skid buffer so the producer can stream one per cycle under backpressure.
- Counts delivered results. Feeds the writeback/consumer side of the datapath.

Parameters:
- WIDTH, 32, data width of operands and sum.
- CNT_W, 16, width of the delivered-result counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer presents a result this cycle.
- in_ready  output  1  stage can accept; registered, equals !skid_valid.
- in_a  input  WIDTH  adder operand a.
- in_b  input  WIDTH  adder operand b.
- in_sum  input  WIDTH  adder output c.
- out_valid  output  1  main register holds a result.
- out_ready  input  1  consumer accepts this cycle.
- out_sum  output  WIDTH  registered sum.
- out_carry  output  1  unsigned carry-out of a+b.
- out_ovf  output  1  signed overflow of a+b.
- result_cnt  output  CNT_W  number of output transfers since reset.
- chk_err  output  1  sticky sum-mismatch flag; see Optional Feature.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, skid_valid=0 (so in_ready=1), out_sum=0, out_carry=0, out_ovf=0, result_cnt=0, chk_err=0. In-flight entries are discarded. The first accept can occur on the first rising edge after rst_n rises.
- Transfer definitions: input accept = in_valid && in_ready; output transfer = out_valid && out_ready.
- Flag computation at accept, from captured values:
  - carry = (in_sum < in_a), unsigned compare.
  - ovf = (in_a[MSB]==in_b[MSB]) && (in_sum[MSB]!=in_a[MSB]).
  - Both flags are stored alongside the sum.
- Storage: main register (drives out_*) and a one-entry skid register.
- Per-cycle update rules:
  - Main empty, or main transferring and skid empty: an accepted entry goes to main.
  - Main full, not transferring, and input accepted: the entry goes to skid; skid_valid becomes 1 and in_ready is 0 next cycle.
  - Main transferring and skid full: skid moves to main and skid_valid becomes 0. in_ready is 0 this cycle, so no accept can occur.
  - Main transferring, skid empty, no accept: out_valid becomes 0.
- Latency: accept in cycle N gives out_valid=1 in cycle N+1. Throughput is 1 per cycle while out_ready=1.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- out_* must remain stable while out_valid && !out_ready.
- result_cnt increments on each output transfer and wraps 2^CNT_W-1 -> 0 silently.
- in_valid while in_ready=0 is ignored; the producer holds its data.
- Full/empty boundaries: holding two entries is full (in_ready=0). No entries: out_valid=0.

Optional Feature:
- Macro: ADDER_RESULT_CHECK_EN.
- Defined:
  - At each accept the block recomputes in_a+in_b (WIDTH bits).
  - If the result differs from in_sum, chk_err is set to 1 on the next edge.
  - chk_err stays set until reset.
  - Flags are still derived from in_sum.
- Undefined: the chk_err port exists, is tied to 0, and no comparator is synthesized.

Test Plan:
- in_a=5, in_b=4, in_sum=9, out_ready=1 -> next cycle out_valid=1, out_sum=9, carry=0, ovf=0; result_cnt=1 after transfer.
- 0xFFFFFFFF+0x00000001, in_sum=0 -> out_sum=0, carry=1, ovf=0. Then 0x7FFFFFFF+0x00000001, in_sum=0x80000000 -> carry=0, ovf=1.
- Backpressure:
  - Stimulus: out_ready=0; send 13+66=79 then 749+619=1368 back-to-back; offer 786+4932=5718.
  - Response: in_ready=0 after second accept and the third is not taken.
  - Then raise out_ready: outputs 79, 1368, 5718 in order, one per cycle; result_cnt=3.
- Reset mid-operation: with both entries full, pulse rst_n low between edges -> out_valid=0, in_ready=1, result_cnt=0 immediately. The next input, 65035+555489=620524, appears alone.
- Streaming: 5 consecutive inputs with out_ready=1 -> 5 outputs on 5 consecutive cycles, in_ready never low.
- With ADDER_RESULT_CHECK_EN: send 13+66 with in_sum=80 -> chk_err=1 next cycle and remains 1 after subsequent correct sums until reset. Without the macro, chk_err stays 0.
